register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - 32-entry x 32-bit general-purpose register file for the single-cycle MIPS-style datapath.
// - Two combinational read ports and one synchronous write port.
// - Sits between instruction decode (register addresses) and the ALU/writeback path.
// - Register 0 is hardwired to zero.
// PARAMETERS
// - DATA_W   32  width of each register and of all data ports
// - ADDR_W   5   register address width; depth = 2**ADDR_W = 32 entries
// PORTS
// - clk        in   1       clock; writes commit on the rising edge
// - rst_n      in   1       asynchronous active-low reset
// - Read1      in   ADDR_W  read port 1 register address
// - Read2      in   ADDR_W  read port 2 register address
// - WriteReg   in   ADDR_W  write port register address
// - RegWrite   in   2       write enable code; any nonzero value = write; both bits are equivalent
// - WriteData  in   DATA_W  data to write
// - Data1      out  DATA_W  contents of register Read1
// - Data2      out  DATA_W  contents of register Read2
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-low (rst_n).
// - Reset: while rst_n=0, all 32 registers clear to 0 immediately, independent of clk.
//   Data1 and Data2 therefore read 0 during reset.
// - Reset release: the first write can commit on the first rising clk edge with rst_n=1.
// - Write: on posedge clk with rst_n=1, if RegWrite!=2'b00 and WriteReg!=0, then regs[WriteReg] <= WriteData.
// - Writes to register 0 are silently discarded. regs[0] always reads 0.
// - Read: DataN = (ReadN==0) ? 0 : regs[ReadN]. Purely combinational, zero-cycle latency;
//   an address change updates DataN within the same cycle.
// - Read-during-write: a read of the register being written returns the OLD value until
//   the write edge, then the NEW value. There is no write-to-read bypass.
// - Both read ports may address the same register, or the write register, simultaneously
//   without conflict.
// - Only a full-word write exists (no byte enables); the write is one-cycle latency.
// - X/Z on RegWrite is treated as no write; the implementation must not corrupt state.
// STRUCTURE
// - Shared package: DATA_W/ADDR_W defaults and the constant REG_ZERO = 0.
// - Storage: one flop array reg [DATA_W-1:0] regs [0:31] with an async-reset always block.
//   Entry 0 may be a constant; no RAM macro is used.
// - Natural sub-module: rf_read_port (address in, array view in, data out, zero-register mux).
//   Instantiate it twice, once per read port.
// TESTING (clk period 100 ns; stimulus changes at negedge)
// - Reset: assert rst_n=0 mid-cycle after arbitrary writes -> Data1=Data2=0 immediately,
//   with no clk edge needed.
// - Write/read: WriteReg=5, WriteData=32'h55555555, RegWrite=1; Read1=5
//   -> Data1=32'h55555555 after the next posedge, Data2 (Read2=0)=0.
// - Second port: WriteReg=10, WriteData=32'haaaaaaaa, RegWrite=1; Read2=10
//   -> Data2=32'haaaaaaaa after posedge; reg 5 still 32'h55555555.
// - Overwrite: WriteReg=5, WriteData=0 -> Data1 on Read1=5 drops to 0 after posedge;
//   likewise reg 10 -> 0.
// - Zero register: WriteReg=0, WriteData=32'hdeadbeef, RegWrite=3 -> Read1=0 still gives 0.
// - Disabled write: RegWrite=0, WriteReg=7, WriteData=32'h12345678 -> reg 7 keeps its prior
//   value (0 after reset). Also check Read1=Read2=WriteReg=7 during an enabled write:
//   old value before the edge, new value after.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and constants for the register file
package register_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: combinational read mux with register 0 forced to zero
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]  regs,
  output logic [DATA_W-1:0]                 data
);
  // zero register reads as constant zero whatever the array holds
  always_comb data = (addr == ADDR_W'(REG_ZERO)) ? '0 : regs[addr];
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 register file, two async read ports, one sync write port
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [1:0]        RegWrite,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] regs;
  // storage: async clear, full-word write; register 0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '0;
    else if ((|RegWrite) && WriteReg != ADDR_W'(REG_ZERO)) regs[WriteReg] <= WriteData;
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (.addr(Read1), .regs(regs), .data(Data1));
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (.addr(Read2), .regs(regs), .data(Data2));
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks against an array model of the register file
module tb_register_file;
  logic        clk, rst_n;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [1:0]  RegWrite;
  logic [31:0] WriteData, Data1, Data2;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model [32];

  register_file dut (.clk(clk), .rst_n(rst_n), .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
                     .RegWrite(RegWrite), .WriteData(WriteData), .Data1(Data1), .Data2(Data2));

  initial clk = 0;
  always #50 clk = ~clk;

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 0) ? 32'h0 : model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 0;
  endtask

  task automatic cyc(input logic [4:0] wa, input logic [31:0] wd, input logic [1:0] we,
                     input logic [4:0] r1, input logic [4:0] r2);
    WriteReg = wa; WriteData = wd; RegWrite = we; Read1 = r1; Read2 = r2;
    #1;
    check("pre_d1", Data1, rd(r1));
    check("pre_d2", Data2, rd(r2));
    @(posedge clk);
    if (we != 0 && wa != 0) model[wa] = wd;
    #1;
    check("post_d1", Data1, rd(r1));
    check("post_d2", Data2, rd(r2));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] wa, r1, r2;
    clear_model();
    rst_n = 0; Read1 = 5; Read2 = 10; WriteReg = 5; WriteData = 32'hffffffff; RegWrite = 1;
    @(negedge clk);
    check("rst_d1", Data1, 32'h0);
    check("rst_d2", Data2, 32'h0);
    rst_n = 1;
    cyc(5'd5, 32'h55555555, 2'd1, 5'd5, 5'd0);
    check("w5", Data1, 32'h55555555);
    check("r0", Data2, 32'h0);
    cyc(5'd10, 32'haaaaaaaa, 2'd1, 5'd5, 5'd10);
    check("w10", Data2, 32'haaaaaaaa);
    check("keep5", Data1, 32'h55555555);
    cyc(5'd5, 32'h0, 2'd2, 5'd5, 5'd10);
    check("ovw5", Data1, 32'h0);
    cyc(5'd10, 32'h0, 2'd3, 5'd5, 5'd10);
    check("ovw10", Data2, 32'h0);
    cyc(5'd0, 32'hdeadbeef, 2'd3, 5'd0, 5'd0);
    check("zero", Data1, 32'h0);
    cyc(5'd7, 32'h12345678, 2'd0, 5'd7, 5'd7);
    check("dis7", Data1, 32'h0);
    cyc(5'd7, 32'hcafef00d, 2'd1, 5'd7, 5'd7);
    check("rdw7", Data2, 32'hcafef00d);
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cyc(wa, $urandom, 2'($urandom_range(0, 3)), r1, r2);
    end
    for (int i = 1; i < 32; i++) if (model[i] == 0) model[i] = 32'h1;
    for (int i = 1; i < 32; i++) cyc(5'(i), model[i], 2'd1, 5'(i), 5'(32 - i));
    Read1 = 5'd3; Read2 = 5'd29;
    #20;
    check("pre_rst_d1", Data1, rd(5'd3));
    rst_n = 0;
    #1;
    clear_model();
    check("arst_d1", Data1, 32'h0);
    check("arst_d2", Data2, 32'h0);
    @(negedge clk);
    rst_n = 1;
    cyc(5'd3, 32'h0badf00d, 2'd1, 5'd3, 5'd29);
    check("after_rst", Data1, 32'h0badf00d);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
